memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 156 +++++++++++++++
 tb/tb_memory_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: arbitrates instruction and data requests onto a single
// RAM port, waits for the RAM to report ACCESS, and returns a one-cycle hit
// (or merror on RAM ERROR / timeout) from a dedicated DONE cycle.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no transaction; arbitrate (data beats instruction) and latch
//   IREQ  | instruction read on the RAM port, waiting for ACCESS
//   DREQ  | data read or write on the RAM port, waiting for ACCESS
//   DONE  | single cycle presenting ihit/dhit/merror; requests not sampled
module memory_responder #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dhit,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merror
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IREQ, DREQ, DONE} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q, data_q, iload_q, dload_q;
  logic              write_q;
  logic              ihit_q, dhit_q, merr_q;
  logic              data_req, access, abort;

  assign data_req = dREN | dWEN;
  assign access   = (ramstate == RAM_ACCESS);
  // ERROR, or the last allowed wait cycle passing without ACCESS
  assign abort    = (ramstate == RAM_ERROR) || (wait_cnt == CNT_LAST);

  // state register, asynchronously returned to IDLE by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // next-state decode and RAM-port / response outputs
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    merror     = 1'b0;
    case (state)
      IDLE: begin
        if (data_req)  next_state = DREQ;
        else if (iREN) next_state = IREQ;
      end
      IREQ: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (access || abort) next_state = DONE;
      end
      DREQ: begin
        ramREN   = !write_q;
        ramWEN   = write_q;
        ramaddr  = addr_q;
        ramstore = data_q;
        if (access || abort) next_state = DONE;
      end
      DONE: begin
        ihit       = ihit_q;
        dhit       = dhit_q;
        merror     = merr_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // request latching, wait counter, load registers and response flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          ihit_q   <= 1'b0;
          dhit_q   <= 1'b0;
          merr_q   <= 1'b0;
          if (data_req) begin
            addr_q  <= daddr & ALIGN_MASK;
            data_q  <= dstore;
            write_q <= dWEN;
          end else if (iREN) begin
            addr_q  <= iaddr & ALIGN_MASK;
            data_q  <= '0;
            write_q <= 1'b0;
          end
        end
        IREQ, DREQ: begin
          if (access) begin
            if (state == IREQ) begin
              iload_q <= ramload;
              ihit_q  <= 1'b1;
            end else begin
              // writes complete with a hit but leave dload alone
              if (!write_q) dload_q <= ramload;
              dhit_q <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (abort) merr_q <= 1'b1;
          end
        end
        default: begin
          wait_cnt <= '0;
          ihit_q   <= 1'b0;
          dhit_q   <= 1'b0;
          merr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign iload = iload_q;
  assign dload = dload_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus randomized transactions,
// each checked against a transaction-level model of latency and results.
module tb_memory_responder;

  localparam int AW = 32;
  localparam int TO = 16;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr, dstore, ramload;
  logic [1:0]    ramstate;
  logic          ihit, dhit, merror, ramREN, ramWEN;
  logic [AW-1:0] iload, dload, ramaddr, ramstore;

  int tests_run = 0;
  int failures  = 0;
  logic [AW-1:0] exp_iload, exp_dload;

  memory_responder #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merror(merror)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;
    #12;
    tests_run++;
    if ({ihit, dhit, merror, ramREN, ramWEN} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, merror, ramREN, ramWEN});
    end
    tests_run++;
    if (iload !== '0 || dload !== '0) begin
      failures++;
      $display("FAIL reset_loads: got iload=%h dload=%h expected 0", iload, dload);
    end
    tests_run++;
    if (ramaddr !== '0 || ramstore !== '0) begin
      failures++;
      $display("FAIL reset_ramport: got ramaddr=%h ramstore=%h expected 0", ramaddr, ramstore);
    end
    @(negedge CLK);
    nRST = 1'b1;
    exp_iload = '0;
    exp_dload = '0;
  endtask

  // kind: 0 instruction fetch, 1 data read, 2 data write.
  // busy: BUSY cycles before the RAM answers; err: answer ERROR instead of ACCESS.
  // Called at a negedge with the responder idle.
  task automatic run_txn(input int kind, input logic [AW-1:0] addr, input logic [AW-1:0] wdata,
                         input logic [AW-1:0] rdata, input int busy, input bit err);
    int n_req, req_seen;
    bit got, wr, exp_err;
    logic [AW-1:0] ea;
    logic [2:0] exp_flags;
    wr = (kind == 2);
    ea = addr & 32'hFFFF_FFFC;
    n_req = (busy + 1 > TO) ? TO : busy + 1;
    exp_err = err || (busy >= TO);
    exp_flags = exp_err ? 3'b001 : (kind == 0) ? 3'b100 : 3'b010;
    iREN = (kind == 0); dREN = (kind == 1); dWEN = (kind == 2);
    if (kind == 0) iaddr = addr; else daddr = addr;
    dstore = wdata;
    ramstate = R_FREE;
    ramload = $urandom;
    req_seen = 0;
    got = 0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(posedge CLK);
      @(negedge CLK);
      // the request is latched; changes on the inputs must not matter now
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
      if (ihit | dhit | merror) begin
        got = 1;
        tests_run++;
        if (cyc !== n_req + 1) begin
          failures++;
          $display("FAIL latency: got %0d cycles expected %0d (kind %0d busy %0d)", cyc, n_req + 1, kind, busy);
        end
        tests_run++;
        if ({ihit, dhit, merror} !== exp_flags) begin
          failures++;
          $display("FAIL response: got ihit/dhit/merror=%b expected %b", {ihit, dhit, merror}, exp_flags);
        end
        tests_run++;
        if ({ramREN, ramWEN} !== 2'b00) begin
          failures++;
          $display("FAIL strobe_in_done: got %b expected 00", {ramREN, ramWEN});
        end
        if (!exp_err && kind == 0) exp_iload = rdata;
        if (!exp_err && kind == 1) exp_dload = rdata;
        tests_run++;
        if (iload !== exp_iload || dload !== exp_dload) begin
          failures++;
          $display("FAIL loads: got iload=%h dload=%h expected %h %h", iload, dload, exp_iload, exp_dload);
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = R_FREE;
      end else if (ramREN | ramWEN) begin
        req_seen++;
        tests_run++;
        if ({ramREN, ramWEN} !== (wr ? 2'b01 : 2'b10) || ramaddr !== ea) begin
          failures++;
          $display("FAIL ram_request: got ren/wen=%b addr=%h expected %b %h", {ramREN, ramWEN}, ramaddr, wr ? 2'b01 : 2'b10, ea);
        end
        if (wr) begin
          tests_run++;
          if (ramstore !== wdata) begin
            failures++;
            $display("FAIL ram_store: got %h expected %h", ramstore, wdata);
          end
        end
        if (req_seen > busy) begin
          ramstate = err ? R_ERROR : R_ACCESS;
          ramload = err ? $urandom : rdata;
        end else begin
          ramstate = R_BUSY;
          ramload = $urandom;
        end
      end else begin
        tests_run++;
        failures++;
        $display("FAIL ram_idle: got no strobe and no response at cycle %0d expected a request", cyc);
        ramstate = R_FREE;
      end
    end
    if (!got) begin
      tests_run++;
      failures++;
      $display("FAIL no_response: got nothing within 40 cycles expected a hit or merror");
    end
    @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if ({ihit, dhit, merror, ramREN, ramWEN} !== 5'b0) begin
      failures++;
      $display("FAIL after_done: got %b expected 00000", {ihit, dhit, merror, ramREN, ramWEN});
    end
  endtask

  task automatic test_fetch_latency();
    run_txn(0, 32'h0000_0043, 32'h0, 32'h2408_0005, 3, 1'b0);
  endtask

  task automatic test_write();
    run_txn(2, 32'h0000_0204, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(1, 32'h0000_0310, 32'h0, 32'hAAAA_0001, 30, 1'b0);
    run_txn(1, 32'h0000_0314, 32'h0, 32'hAAAA_0002, 15, 1'b0);
    run_txn(0, 32'h0000_0318, 32'h0, 32'hAAAA_0003, 16, 1'b0);
  endtask

  task automatic test_ram_error();
    run_txn(1, 32'h0000_0420, 32'h0, 32'h5555_0001, 2, 1'b1);
    run_txn(2, 32'h0000_0424, 32'h0BAD_F00D, 32'h0, 0, 1'b1);
  endtask

  task automatic test_priority();
    int cyc_d, cyc_i;
    bit both;
    logic [AW-1:0] rd1, rd2;
    rd1 = $urandom; rd2 = $urandom;
    cyc_d = 0; cyc_i = 0; both = 0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0000_0088; daddr = 32'h0000_0100;
    ramstate = R_ACCESS; ramload = rd1;
    for (int cyc = 1; cyc <= 20 && cyc_i == 0; cyc++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (ihit && dhit) both = 1;
      if (cyc == 1) begin
        tests_run++;
        if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin
          failures++;
          $display("FAIL prio_first: got addr=%h ren=%b expected 00000100 1", ramaddr, ramREN);
        end
      end
      if (cyc == 4) begin
        tests_run++;
        if (ramaddr !== 32'h88 || ramREN !== 1'b1) begin
          failures++;
          $display("FAIL prio_second: got addr=%h ren=%b expected 00000088 1", ramaddr, ramREN);
        end
      end
      if (dhit && cyc_d == 0) begin
        cyc_d = cyc;
        exp_dload = rd1;
        tests_run++;
        if (dload !== rd1) begin
          failures++;
          $display("FAIL prio_dload: got %h expected %h", dload, rd1);
        end
        dREN = 1'b0;
        ramload = rd2;
      end
      if (ihit) begin
        cyc_i = cyc;
        exp_iload = rd2;
        tests_run++;
        if (iload !== rd2) begin
          failures++;
          $display("FAIL prio_iload: got %h expected %h", iload, rd2);
        end
        iREN = 1'b0;
        ramstate = R_FREE;
      end
    end
    tests_run++;
    if (cyc_d !== 2 || cyc_i !== 5) begin
      failures++;
      $display("FAIL prio_order: got dhit@%0d ihit@%0d expected 2 and 5", cyc_d, cyc_i);
    end
    tests_run++;
    if (both) begin
      failures++;
      $display("FAIL prio_exclusive: got ihit and dhit together expected never");
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    a = $urandom;
    iREN = 1'b1; iaddr = a; ramstate = R_BUSY;
    repeat (2) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    #2 nRST = 1'b0;
    #1;
    tests_run++;
    if ({ihit, dhit, merror, ramREN, ramWEN} !== 5'b0 || ramaddr !== '0 || iload !== '0 || dload !== '0) begin
      failures++;
      $display("FAIL reset_async: got flags=%b ramaddr=%h iload=%h dload=%h expected all 0",
               {ihit, dhit, merror, ramREN, ramWEN}, ramaddr, iload, dload);
    end
    ramstate = R_ACCESS;
    @(posedge CLK);
    #1;
    tests_run++;
    if ({ihit, merror} !== 2'b0) begin
      failures++;
      $display("FAIL reset_nohit: got ihit/merror=%b expected 00", {ihit, merror});
    end
    @(negedge CLK);
    nRST = 1'b1;
    exp_iload = '0;
    exp_dload = '0;
    run_txn(0, a, 32'h0, 32'hC0DE_0001, 1, 1'b0);
  endtask

  task automatic test_random();
    int kind, busy;
    bit err;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      busy = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4);
      err = ($urandom_range(0, 7) == 0);
      run_txn(kind, $urandom, $urandom, $urandom, busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_write();
    test_timeout();
    test_ram_error();
    test_priority();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
